// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-N stream demux and its per-channel registers.
package demux_pkg;

    localparam int DEMUX_DEF_WIDTH = 4;
    localparam int DEMUX_DEF_N     = 4;
    localparam int ERR_CNT_W       = 8;

    // Select width for n channels; a single channel still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// One-entry output register for a single demux channel: load wins over drain.
module demux_ch_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             o_ready,
    output logic [WIDTH-1:0] q,
    output logic             o_valid
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        if (load) begin
            q_d     = d;
            valid_d = 1'b1;
        end else if (valid_q && o_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign q       = q_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/demux_1ton_stream.sv
// 1-to-N valid/ready stream demux with out-of-range drop counter.
// Optional broadcast input enabled by macro DEMUX_BCAST_EN.
module demux_1ton_stream
    import demux_pkg::*;
#(
    parameter  int WIDTH = DEMUX_DEF_WIDTH,
    parameter  int N     = DEMUX_DEF_N,
    localparam int SEL_W = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     i,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [SEL_W-1:0]     sel,
    output logic [N*WIDTH-1:0]   o,
    output logic [N-1:0]         o_valid,
    input  logic [N-1:0]         o_ready,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef DEMUX_BCAST_EN
    ,
    input  logic                 bcast
`endif
);

    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

    logic [N-1:0]         ch_free;
    logic [N-1:0]         ch_load;
    logic [N-1:0]         ch_valid;
    logic                 sel_in_range;
    logic                 sel_free;
    logic                 bcast_w;
    logic                 accept;
    logic                 i_ready_c;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

`ifdef DEMUX_BCAST_EN
    assign bcast_w = bcast;
`else
    assign bcast_w = 1'b0;
`endif

    always_comb begin
        ch_free      = ~ch_valid | o_ready;
        sel_in_range = ({1'b0, sel} < N_LIM);
        sel_free     = 1'b0;
        // Explicit decode keeps the read in range when sel >= N.
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(sel) == k) begin
                sel_free = ch_free[k];
            end
        end

        if (bcast_w) begin
            i_ready_c = &ch_free;
        end else if (sel_in_range) begin
            i_ready_c = sel_free;
        end else begin
            i_ready_c = 1'b1;
        end

        accept  = i_valid & i_ready_c;
        ch_load = '0;
        for (int unsigned k = 0; k < N; k++) begin
            ch_load[k] = accept & (bcast_w | (32'(sel) == k));
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !bcast_w && !sel_in_range && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_ch
        demux_ch_reg #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .load    (ch_load[k]),
            .d       (i),
            .o_ready (o_ready[k]),
            .q       (o[k*WIDTH +: WIDTH]),
            .o_valid (ch_valid[k])
        );
    end

    assign i_ready = i_ready_c;
    assign o_valid = ch_valid;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Self-checking bench for demux_1ton_stream: directed cases, randomized run against a model, parameter sweep.
module tb_demux_1ton_stream;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Default instance: WIDTH=4, N=4
    logic [3:0]  a_i = '0;
    logic        a_iv = 1'b0, a_ir;
    logic [1:0]  a_sel = '0;
    logic [15:0] a_o;
    logic [3:0]  a_ov, a_or = '0;
    logic [7:0]  a_err;
    // N=3 instance for out-of-range behaviour
    logic [3:0]  b_i = '0;
    logic        b_iv = 1'b0, b_ir;
    logic [1:0]  b_sel = '0;
    logic [11:0] b_o;
    logic [2:0]  b_ov, b_or = '0;
    logic [7:0]  b_err;
    // WIDTH=8 sweep instances
    logic [7:0]   c2_i = '0, c5_i = '0, c16_i = '0;
    logic         c2_iv = 1'b0, c5_iv = 1'b0, c16_iv = 1'b0;
    logic         c2_ir, c5_ir, c16_ir;
    logic [0:0]   c2_sel = '0;
    logic [2:0]   c5_sel = '0;
    logic [3:0]   c16_sel = '0;
    logic [15:0]  c2_o;
    logic [39:0]  c5_o;
    logic [127:0] c16_o;
    logic [1:0]   c2_ov, c2_or = '0;
    logic [4:0]   c5_ov, c5_or = '0;
    logic [15:0]  c16_ov, c16_or = '0;
    logic [7:0]   c2_err, c5_err, c16_err;
`ifdef DEMUX_BCAST_EN
    logic a_bc = 1'b0, b_bc = 1'b0, c2_bc = 1'b0, c5_bc = 1'b0, c16_bc = 1'b0;
`endif

    demux_1ton_stream #(.WIDTH(4), .N(4)) u_dut (
        .clk(clk), .rst(rst), .i(a_i), .i_valid(a_iv), .i_ready(a_ir), .sel(a_sel),
        .o(a_o), .o_valid(a_ov), .o_ready(a_or), .err_cnt(a_err)
`ifdef DEMUX_BCAST_EN
        , .bcast(a_bc)
`endif
    );

    demux_1ton_stream #(.WIDTH(4), .N(3)) u_dut3 (
        .clk(clk), .rst(rst), .i(b_i), .i_valid(b_iv), .i_ready(b_ir), .sel(b_sel),
        .o(b_o), .o_valid(b_ov), .o_ready(b_or), .err_cnt(b_err)
`ifdef DEMUX_BCAST_EN
        , .bcast(b_bc)
`endif
    );

    demux_1ton_stream #(.WIDTH(8), .N(2)) u_dut_n2 (
        .clk(clk), .rst(rst), .i(c2_i), .i_valid(c2_iv), .i_ready(c2_ir), .sel(c2_sel),
        .o(c2_o), .o_valid(c2_ov), .o_ready(c2_or), .err_cnt(c2_err)
`ifdef DEMUX_BCAST_EN
        , .bcast(c2_bc)
`endif
    );

    demux_1ton_stream #(.WIDTH(8), .N(5)) u_dut_n5 (
        .clk(clk), .rst(rst), .i(c5_i), .i_valid(c5_iv), .i_ready(c5_ir), .sel(c5_sel),
        .o(c5_o), .o_valid(c5_ov), .o_ready(c5_or), .err_cnt(c5_err)
`ifdef DEMUX_BCAST_EN
        , .bcast(c5_bc)
`endif
    );

    demux_1ton_stream #(.WIDTH(8), .N(16)) u_dut_n16 (
        .clk(clk), .rst(rst), .i(c16_i), .i_valid(c16_iv), .i_ready(c16_ir), .sel(c16_sel),
        .o(c16_o), .o_valid(c16_ov), .o_ready(c16_or), .err_cnt(c16_err)
`ifdef DEMUX_BCAST_EN
        , .bcast(c16_bc)
`endif
    );

    // Reference model for the N=3 instance: occupancy, stored word, drop count.
    bit         m_valid [3];
    logic [3:0] m_data  [3];
    int         m_err;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  s;
        bit  exp_rdy;
        logic [15:0] one;

        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end
        m_err = 0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_a_o_valid", 64'(a_ov), 64'h0);
        check("rst_a_o", 64'(a_o), 64'h0);
        check("rst_a_err_cnt", 64'(a_err), 64'h0);
        check("rst_b_o_valid", 64'(b_ov), 64'h0);
        check("rst_b_err_cnt", 64'(b_err), 64'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Unicast fill of all four channels with no consumer
        for (int k = 0; k < 4; k++) begin
            a_i   = 4'hA + 4'(k);
            a_sel = 2'(k);
            a_iv  = 1'b1;
            @(negedge clk);
            check("fill_i_ready", 64'(a_ir), 64'h1);
            @(posedge clk); #1;
        end
        a_iv = 1'b0;
        @(negedge clk);
        check("fill_o_valid", 64'(a_ov), 64'hF);
        check("fill_o", 64'(a_o), 64'hDCBA);
        a_iv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_sel = 2'(k);
            #1;
            check("full_i_ready", 64'(a_ir), 64'h0);
        end
        a_iv = 1'b0;
        @(posedge clk); #1;

        // Backpressure on channel 2, then release
        a_i = 4'h5; a_sel = 2'd2; a_iv = 1'b1; a_or = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_i_ready", 64'(a_ir), 64'h0);
            check("bp_o2_held", 64'(a_o[11:8]), 64'hC);
            @(posedge clk); #1;
        end
        a_or = 4'b0100;
        @(negedge clk);
        check("bp_release_i_ready", 64'(a_ir), 64'h1);
        @(posedge clk); #1;
        a_iv = 1'b0; a_or = '0;
        @(negedge clk);
        check("bp_o_after", 64'(a_o), 64'hD5BA);
        check("bp_o_valid_after", 64'(a_ov), 64'hF);
        @(posedge clk); #1;

        // Randomized traffic on N=3, including out-of-range selects
        for (int cyc = 0; cyc < 800; cyc++) begin
            b_i   = 4'($urandom);
            b_sel = 2'($urandom);
            b_iv  = ($urandom_range(0, 3) != 0);
            b_or  = 3'($urandom);
            @(negedge clk);
            s = int'(b_sel);
            exp_rdy = (s >= 3) ? 1'b1 : (!m_valid[s] || b_or[s]);
            if (b_iv) check("rnd_i_ready", 64'(b_ir), 64'(exp_rdy));
            for (int k = 0; k < 3; k++) begin
                check("rnd_o_valid", 64'(b_ov[k]), 64'(m_valid[k]));
                if (m_valid[k]) check("rnd_o_data", 64'(b_o[k*4 +: 4]), 64'(m_data[k]));
            end
            check("rnd_err_cnt", 64'(b_err), 64'(m_err));
            for (int k = 0; k < 3; k++) begin
                if (m_valid[k] && b_or[k]) m_valid[k] = 1'b0;
            end
            if (b_iv && exp_rdy) begin
                if (s < 3) begin
                    m_valid[s] = 1'b1;
                    m_data[s]  = b_i;
                end else if (m_err < 255) begin
                    m_err++;
                end
            end
            @(posedge clk); #1;
        end

        // Sustained out-of-range traffic saturates the drop counter
        b_sel = 2'd3; b_iv = 1'b1; b_or = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            b_i = 4'($urandom);
            @(negedge clk);
            check("oor_i_ready", 64'(b_ir), 64'h1);
            @(posedge clk); #1;
        end
        b_iv = 1'b0;
        @(negedge clk);
        check("oor_err_sat", 64'(b_err), 64'hFF);
        for (int k = 0; k < 3; k++) begin
            check("oor_o_valid_kept", 64'(b_ov[k]), 64'(m_valid[k]));
            if (m_valid[k]) check("oor_o_data_kept", 64'(b_o[k*4 +: 4]), 64'(m_data[k]));
        end
        @(posedge clk); #1;

        // Reset asserted between edges clears state before the next edge
        #2 rst = 1'b1;
        #1;
        check("midrst_a_o_valid", 64'(a_ov), 64'h0);
        check("midrst_a_o", 64'(a_o), 64'h0);
        check("midrst_b_err_cnt", 64'(b_err), 64'h0);
        check("midrst_b_o_valid", 64'(b_ov), 64'h0);
        @(posedge clk); #1;
        a_i = 4'h6; a_sel = 2'd0; a_iv = 1'b1;
        @(posedge clk); #1;
        check("inrst_no_accept", 64'(a_ov), 64'h0);
        a_iv = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Normal operation resumes after reset release
        a_i = 4'h9; a_sel = 2'd1; a_iv = 1'b1;
        @(negedge clk);
        check("resume_i_ready", 64'(a_ir), 64'h1);
        @(posedge clk); #1;
        a_iv = 1'b0;
        @(negedge clk);
        check("resume_o_valid", 64'(a_ov), 64'h2);
        check("resume_o1", 64'(a_o[7:4]), 64'h9);
        @(posedge clk); #1;

`ifdef DEMUX_BCAST_EN
        a_or = 4'hF;
        @(posedge clk); #1;
        a_or = '0; a_i = 4'hE; a_sel = 2'd3; a_iv = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        @(negedge clk);
        check("bc_pre_o_valid", 64'(a_ov), 64'h8);
        a_bc = 1'b1; a_i = 4'h7; a_iv = 1'b1; a_sel = 2'd0;
        #1;
        check("bc_blocked_i_ready", 64'(a_ir), 64'h0);
        a_or = 4'b1000;
        #1;
        check("bc_open_i_ready", 64'(a_ir), 64'h1);
        @(posedge clk); #1;
        a_iv = 1'b0; a_bc = 1'b0; a_or = '0;
        @(negedge clk);
        check("bc_o_valid", 64'(a_ov), 64'hF);
        check("bc_o", 64'(a_o), 64'h7777);
        check("bc_err_cnt", 64'(a_err), 64'h0);
        @(posedge clk); #1;
`endif

        // Parameter sweep: one word per select value, then drain
        for (int s2 = 0; s2 < 16; s2++) begin
            one = 16'(1) << s2;
            c2_i = 8'h3C; c5_i = 8'h3C; c16_i = 8'h3C;
            c2_sel = 1'(s2); c5_sel = 3'(s2); c16_sel = 4'(s2);
            c2_iv = (s2 < 2); c5_iv = (s2 < 5); c16_iv = 1'b1;
            c2_or = '0; c5_or = '0; c16_or = '0;
            @(negedge clk);
            if (s2 < 2) check("sw2_i_ready", 64'(c2_ir), 64'h1);
            if (s2 < 5) check("sw5_i_ready", 64'(c5_ir), 64'h1);
            check("sw16_i_ready", 64'(c16_ir), 64'h1);
            @(posedge clk); #1;
            c2_iv = 1'b0; c5_iv = 1'b0; c16_iv = 1'b0;
            @(negedge clk);
            check("sw2_o_valid", 64'(c2_ov), (s2 < 2) ? 64'(one[1:0]) : 64'h0);
            check("sw5_o_valid", 64'(c5_ov), (s2 < 5) ? 64'(one[4:0]) : 64'h0);
            check("sw16_o_valid", 64'(c16_ov), 64'(one));
            if (s2 < 2) check("sw2_o", 64'(c2_o[s2*8 +: 8]), 64'h3C);
            if (s2 < 5) check("sw5_o", 64'(c5_o[s2*8 +: 8]), 64'h3C);
            check("sw16_o", 64'(c16_o[s2*8 +: 8]), 64'h3C);
            c2_or = '1; c5_or = '1; c16_or = '1;
            @(posedge clk); #1;
            c2_or = '0; c5_or = '0; c16_or = '0;
        end
        check("sw2_err_cnt", 64'(c2_err), 64'h0);
        check("sw5_err_cnt", 64'(c5_err), 64'h0);
        check("sw16_err_cnt", 64'(c16_err), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1ton_stream.md
DEMUX_1TON_STREAM -- requirements
Module: demux_1ton_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width in bits (>=1).
REQ-002 SHALL have parameter N, default 4, output channel count (2..16).
REQ-003 SHALL have derived localparam SEL_W = max(1, clog2(N)), not overridable.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i  input  WIDTH  input data.
REQ-007 SHALL have port i_valid  input  1  input data valid.
REQ-008 SHALL have port i_ready  output  1  block can accept input this cycle.
REQ-009 SHALL have port sel  input  SEL_W  destination channel, sampled with i.
REQ-010 SHALL have port o  output  N*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port o_valid  output  N  per-channel data valid.
REQ-012 SHALL have port o_ready  input  N  per-channel consumer ready.
REQ-013 SHALL have port err_cnt  output  8  count of dropped out-of-range transfers.

Function
REQ-014 SHALL give each channel a one-entry output register; occupancy drives o_valid[k].
REQ-015 SHALL define an accept as i_valid & i_ready on a rising clk edge.
REQ-016 SHALL define a channel drain as o_valid[k] & o_ready[k] on a rising clk edge.
REQ-017 SHALL drive i_ready = ~o_valid[sel] | o_ready[sel] for sel < N, combinationally.
REQ-018 SHALL load i into channel sel on accept, setting o_valid[sel] next cycle (latency 1).
REQ-019 SHALL allow simultaneous drain and accept on one channel; the new word replaces the old and o_valid stays 1.
REQ-020 SHALL leave o and o_valid of non-selected channels unchanged, except for their own drains.
REQ-021 SHALL hold o[k] stable while o_valid[k]=1 and o_ready[k]=0.
REQ-022 SHALL drive i_ready = 1 for sel >= N; on accept, discard the data and increment err_cnt.
REQ-023 SHALL saturate err_cnt at 8'hFF.
REQ-024 SHALL leave o[k] unchanged when its channel drains without reload; value is don't-care while o_valid[k]=0.
REQ-025 SHALL treat i_ready as undefined while i_valid=0; bench checks it only when i_valid=1.

Reset
REQ-026 SHALL clear all o_valid bits, all o words and err_cnt to 0 immediately on rst high, independent of clk.
REQ-027 SHALL discard any in-flight data in all channels when rst is asserted mid-operation.
REQ-028 SHALL perform no accept while rst is high; i_ready may be any value.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-030 SHALL support macro DEMUX_BCAST_EN.
REQ-031 With DEMUX_BCAST_EN defined, SHALL add input port bcast (1 bit).
REQ-032 With DEMUX_BCAST_EN, when bcast=1, SHALL drive i_ready = AND over k of (~o_valid[k] | o_ready[k]).
REQ-033 With DEMUX_BCAST_EN, when bcast=1, SHALL load i into all N channels on accept and ignore sel; err_cnt is unchanged.
REQ-034 Without DEMUX_BCAST_EN, SHALL have no bcast port and keep unicast behaviour only.

Structure
REQ-035 SHALL place DEMUX_DEF_WIDTH=4, DEMUX_DEF_N=4 and ERR_CNT_W=8 in shared package demux_pkg.
REQ-036 SHALL implement the per-channel register as sub-module demux_ch_reg, with ports clk, rst, load, d, o_ready, q, o_valid, instantiated N times via generate.

Verification
REQ-037 Reset and unicast: rst pulse, then i=4'hA,sel=0 / 4'hB,sel=1 / 4'hC,sel=2 / 4'hD,sel=3 with all o_ready=0 -> o_valid=4'b1111; o = {D,C,B,A}; i_ready=0 for any further i_valid on sel 0..3.
REQ-038 Backpressure: channel 2 full (4'hC), o_ready[2]=0, i=4'h5,sel=2 held 3 cycles -> i_ready=0 and o[2]=4'hC held; raise o_ready[2] -> 4'h5 accepted the same cycle, o[2]=4'h5 next cycle, o_valid[2] stays 1.
REQ-039 Out-of-range: N=3, sel=3, i_valid=1 for 300 cycles -> i_ready=1; err_cnt reaches 8'hFF and holds; channels 0..2 unchanged.
REQ-040 Reset mid-operation: channels 0 and 1 full, rst asserted between clock edges -> o_valid=0 and err_cnt=0 before the next edge.
REQ-041 Broadcast (DEMUX_BCAST_EN): bcast=1, i=4'h7, channel 3 full with o_ready[3]=0 -> i_ready=0; raise o_ready[3] -> all four channels hold 4'h7 next cycle.
REQ-042 Parameter sweep: WIDTH=8 and N=2, 5, 16 -> each sel value 0..N-1 routes exactly one word, 8'h3C, to channel sel only.
